// File: rtl/scff_test_pkg.sv
// Shared FSM encoding and default sizing for the scan-chain flop tester.
package scff_test_pkg;

   localparam int DEF_SCAN_CHAIN_SIZE = 8;
   localparam int DEF_CHECK_LEN       = 3;
   localparam int DEF_ERR_W           = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INJECT,
      ST_SHIFT,
      ST_CHECK,
      ST_DONE
   } state_t;

endpackage

// File: rtl/scff_err_counter.sv
// Compares the observed scan tail against the expected bit and keeps a
// saturating count of mismatches; mismatch is also exported for same-cycle use.
module scff_err_counter #(
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             check_en,
   input  logic             expected,
   input  logic             observed,
   output logic             mismatch,
   output logic [ERR_W-1:0] count
);

   assign mismatch = check_en && (expected != observed);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (mismatch && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/scff_test_ctrl.sv
// Injects a single 1 at the scan-chain head, then checks that it emerges at the
// tail exactly SCAN_CHAIN_SIZE cycles later and nowhere else in the window.
module scff_test_ctrl
   import scff_test_pkg::*;
#(
   parameter int SCAN_CHAIN_SIZE = DEF_SCAN_CHAIN_SIZE,
   parameter int CHECK_LEN       = DEF_CHECK_LEN,
   parameter int ERR_W           = DEF_ERR_W
) (
   input  logic             op_clk,
   input  logic             greset,
   input  logic             start,
   input  logic             abort,
   input  logic             sc_tail,
   output logic             sc_head,
   output logic             test_en,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count
);

   localparam int CNT_W = $clog2(SCAN_CHAIN_SIZE + CHECK_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_SHIFT  = CNT_W'(SCAN_CHAIN_SIZE - 1);
   localparam logic [CNT_W-1:0] FIRST_CHECK = CNT_W'(SCAN_CHAIN_SIZE);
   localparam logic [CNT_W-1:0] LAST_CHECK  = CNT_W'(SCAN_CHAIN_SIZE + CHECK_LEN - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             run_clear;
   logic             check_en;
   logic             expected;
   logic             mismatch;

   assign run_clear = (state == ST_IDLE) && start && !abort;
   // The cycle that carries an abort is not scored: the run is being cancelled.
   assign check_en  = ((state == ST_SHIFT) || (state == ST_CHECK)) && !abort;
   assign expected  = (state == ST_CHECK) && (cnt == FIRST_CHECK);

   scff_err_counter #(
      .ERR_W (ERR_W)
   ) u_err (
      .clk      (op_clk),
      .rst      (greset),
      .clear    (run_clear),
      .check_en (check_en),
      .expected (expected),
      .observed (sc_tail),
      .mismatch (mismatch),
      .count    (err_count)
   );

   always_ff @(posedge op_clk or posedge greset) begin
      if (greset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         sc_head <= 1'b0;
         test_en <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         pass    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  state   <= ST_INJECT;
                  cnt     <= '0;
                  sc_head <= 1'b1;
                  test_en <= 1'b1;
                  busy    <= 1'b1;
                  pass    <= 1'b0;
               end
            end
            ST_INJECT, ST_SHIFT, ST_CHECK: begin
               if (abort) begin
                  state   <= ST_IDLE;
                  sc_head <= 1'b0;
                  test_en <= 1'b0;
                  busy    <= 1'b0;
                  pass    <= 1'b0;
               end else begin
                  cnt     <= cnt + 1'b1;
                  sc_head <= 1'b0;
                  if (state == ST_INJECT) begin
                     state <= ST_SHIFT;
                  end else if ((state == ST_SHIFT) && (cnt == LAST_SHIFT)) begin
                     state <= ST_CHECK;
                  end else if ((state == ST_CHECK) && (cnt == LAST_CHECK)) begin
                     // Include the mismatch being registered on this same edge.
                     state   <= ST_DONE;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     test_en <= 1'b0;
                     pass    <= (err_count == '0) && !mismatch;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scff_test_ctrl.sv
// Directed bench: a behavioural scan chain in the fabric, per-cycle output expectations queued per run.
module tb_scff_test_ctrl;

   localparam int N  = 8;
   localparam int C  = 3;
   localparam int NC = N + C;

   logic       op_clk;
   logic       greset;
   logic       start;
   logic       abort;
   logic       sc_tail;
   logic       sc_head, test_en, busy, done, pass;
   logic [7:0] err_count;
   logic       sc_head2, test_en2, busy2, done2, pass2;
   logic [2:0] err_count2;

   logic [15:0] chain;
   logic        chain_clr;
   logic        stuck;
   int          chain_len;

   int checks   = 0;
   int failures = 0;

   logic [3:0] exp_q[$];

   scff_test_ctrl #(.SCAN_CHAIN_SIZE(N), .CHECK_LEN(C), .ERR_W(8)) dut (
      .op_clk(op_clk), .greset(greset), .start(start), .abort(abort), .sc_tail(sc_tail),
      .sc_head(sc_head), .test_en(test_en), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count)
   );

   // Narrow counter copy, used only to observe saturation.
   scff_test_ctrl #(.SCAN_CHAIN_SIZE(N), .CHECK_LEN(C), .ERR_W(3)) dut_sat (
      .op_clk(op_clk), .greset(greset), .start(start), .abort(abort), .sc_tail(sc_tail),
      .sc_head(sc_head2), .test_en(test_en2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err_count2)
   );

   initial op_clk = 1'b0;
   always #5 op_clk = ~op_clk;

   always @(posedge op_clk) begin
      if (chain_clr)    chain <= '0;
      else if (test_en) chain <= {chain[14:0], sc_head};
   end

   assign sc_tail = stuck | chain[chain_len-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_outs(input int n, input int abort_at);
      // {sc_head, test_en, busy, done}
      if (abort_at >= 0 && n > abort_at) return 4'b0000;
      if (n == 0)  return 4'b1110;
      if (n < NC)  return 4'b0110;
      if (n == NC) return 4'b0001;
      return 4'b0000;
   endfunction

   function automatic int exp_errs(input int len, input bit stk, input int abort_at);
      int e = 0;
      for (int n = 1; n < NC; n++) begin
         if (abort_at < 0 || n < abort_at) begin
            if ((n == N) != (stk || (n == len))) e++;
         end
      end
      return e;
   endfunction

   // Called at a negedge. Runs cycles 0..NC+1 of one test and checks outputs each cycle.
   task automatic run(input int len, input bit stk, input int abort_at, input int repulse_at,
                      input bit keep_start, input bit started, input int reset_at);
      logic [3:0] e;
      int         errs;
      chain_len = len;
      stuck     = stk;
      errs      = exp_errs(len, stk, abort_at);
      if (!started) begin
         start     = 1'b1;
         chain_clr = 1'b1;
      end
      for (int n = 0; n <= NC + 1; n++) exp_q.push_back(exp_outs(n, abort_at));
      for (int n = 0; n <= NC + 1; n++) begin
         @(negedge op_clk);
         chain_clr = 1'b0;
         e = exp_q.pop_front();
         chk($sformatf("cyc%0d_outs", n), {28'd0, sc_head, test_en, busy, done}, {28'd0, e});
         if (n == 0) chk("cyc0_err_cleared", {24'd0, err_count}, 32'd0);
         if (n == reset_at) begin
            greset = 1'b1;
            #1;
            chk("async_rst_outs", {27'd0, sc_head, test_en, busy, done, pass}, 32'd0);
            chk("async_rst_err", {24'd0, err_count}, 32'd0);
            start = 1'b0;
            exp_q.delete();
            @(negedge op_clk);
            greset = 1'b0;
            return;
         end
         start = keep_start || (n == repulse_at);
         abort = (n == abort_at);
      end
      chk("err_count", {24'd0, err_count}, errs);
      chk("err_count_sat", {29'd0, err_count2}, (errs > 7) ? 7 : errs);
      chk("pass", {31'd0, pass}, {31'd0, (abort_at < 0) && (errs == 0)});
   endtask

   initial begin
      greset    = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      stuck     = 1'b0;
      chain_len = N;
      chain_clr = 1'b1;
      repeat (2) @(negedge op_clk);
      chk("rst_outs", {27'd0, sc_head, test_en, busy, done, pass}, 32'd0);
      chk("rst_err", {24'd0, err_count}, 32'd0);
      // start and abort together in IDLE: stays idle
      greset = 1'b0;
      start  = 1'b1;
      abort  = 1'b1;
      @(negedge op_clk);
      chk("start_abort_idle", {30'd0, busy, test_en}, 32'd0);
      start = 1'b0;
      abort = 1'b0;

      run(8, 1'b0, -1, -1, 1'b0, 1'b0, -1);   // ideal chain
      run(7, 1'b0, -1, -1, 1'b0, 1'b0, -1);   // short chain: 2 errors
      run(8, 1'b1, -1, -1, 1'b0, 1'b0, -1);   // stuck tail: 9 errors
      run(8, 1'b0,  4, -1, 1'b0, 1'b0, -1);   // abort at cycle 4
      run(8, 1'b0, -1,  5, 1'b0, 1'b0, -1);   // start re-pulse ignored
      run(8, 1'b1, -1, -1, 1'b1, 1'b0, -1);   // start held, failing run
      run(8, 1'b0, -1, -1, 1'b0, 1'b1, -1);   // back-to-back second run
      run(7, 1'b0, -1, -1, 1'b0, 1'b0,  9);   // async reset mid-CHECK
      run(8, 1'b0, -1, -1, 1'b0, 1'b0, -1);   // first start after reset

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/scff_test_ctrl.md
SCFF_TEST_CTRL -- requirements
Module: scff_test_ctrl

Interface
REQ-001 SHALL have parameter SCAN_CHAIN_SIZE, default 8: number of flops in the scan chain under test; legal minimum 2.
REQ-002 SHALL have parameter CHECK_LEN, default 3: number of cycles sc_tail is checked once the pulse is due; legal minimum 2.
REQ-003 SHALL have parameter ERR_W, default 8: width of the error counter.
REQ-004 SHALL have port op_clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port greset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: level-sampled request to begin a test run.
REQ-007 SHALL have port abort, input, 1 bit: cancels an in-progress run.
REQ-008 SHALL have port sc_tail, input, 1 bit: scan-chain tail observed from the fabric.
REQ-009 SHALL have port sc_head, output, 1 bit: scan-chain head driven into the fabric.
REQ-010 SHALL have port test_en, output, 1 bit: fabric scan-mode enable.
REQ-011 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at normal run completion.
REQ-013 SHALL have port pass, output, 1 bit: result of the last completed run.
REQ-014 SHALL have port err_count, output, ERR_W bits: mismatches counted in the current or last run.

Function
REQ-015 SHALL implement FSM states IDLE, INJECT, SHIFT, CHECK, DONE; cycle n = n-th cycle after the edge that samples start (INJECT = cycle 0).
REQ-016 IDLE: start=1 and abort=0 SHALL move to INJECT, clear err_count, clear pass.
REQ-017 INJECT (cycle 0): sc_head=1, test_en=1, busy=1; next state SHIFT.
REQ-018 SHIFT (cycles 1..SCAN_CHAIN_SIZE-1): sc_head=0, test_en=1; each cycle with sc_tail!=0 SHALL count one error (early pulse).
REQ-019 CHECK (cycles SCAN_CHAIN_SIZE..SCAN_CHAIN_SIZE+CHECK_LEN-1): expect sc_tail=1 on the first cycle and 0 on the rest; each mismatch SHALL count one error.
REQ-020 DONE (cycle SCAN_CHAIN_SIZE+CHECK_LEN): done=1, busy=0, test_en=0; pass SHALL be set to (err_count==0 including any error registered this run) and held until the next accepted start; next state IDLE.
REQ-021 err_count SHALL saturate at 2^ERR_W-1, never wrap.
REQ-022 The cycle counter SHALL be $clog2(SCAN_CHAIN_SIZE+CHECK_LEN+1) bits wide and cleared on entering INJECT.
REQ-023 start while busy SHALL be ignored; start held high through DONE SHALL launch a new run from IDLE on the following cycle.
REQ-024 abort in INJECT/SHIFT/CHECK SHALL return to IDLE on the next edge with sc_head=0, test_en=0, pass=0, done never pulsed; err_count retained.
REQ-025 abort and start both high in IDLE: abort SHALL win, FSM stays IDLE.
REQ-026 In IDLE: sc_head=0, test_en=0, busy=0, done=0.

Reset
REQ-027 greset=1 SHALL immediately force state IDLE, counter 0, err_count 0, sc_head 0, test_en 0, busy 0, done 0, pass 0, regardless of state.
REQ-028 After greset deasserts, the first start SHALL be accepted on the first rising edge of op_clk.

Structure
REQ-029 State encoding enum and default parameter values SHALL live in shared package scff_test_pkg.
REQ-030 Mismatch detection plus saturating counter SHALL be sub-module scff_err_counter (inputs: clear, check_en, expected, observed).

Verification (SCAN_CHAIN_SIZE=8, CHECK_LEN=3)
REQ-031 Ideal 8-flop chain model, start pulse -> sc_head=1 only at cycle 0, tail=1 at cycle 8, done at cycle 11, pass=1, err_count=0.
REQ-032 7-flop chain model -> tail=1 at cycle 7 (SHIFT error) and 0 at cycle 8 (CHECK error); err_count=2, pass=0.
REQ-033 sc_tail stuck at 1 -> 7 SHIFT errors + 2 CHECK errors; err_count=9, pass=0.
REQ-034 abort at cycle 4 -> busy=0, test_en=0 from cycle 5; no done pulse; pass=0.
REQ-035 greset asserted asynchronously during CHECK (cycle 9) -> all outputs 0 before the next op_clk edge; a new start after release runs a full passing test.
REQ-036 start re-pulsed at cycle 5 is ignored; start held high across runs -> second run starts the cycle after DONE with err_count cleared.
